// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM encoding and default width for the ALU command issuer
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/alu_timeout_ctr.sv
// rtl/alu_timeout_ctr.sv - clear/enable saturating 8-bit counter that flags the last allowed wait cycle
module alu_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    // Value held by the counter during the final cycle the ALU is allowed to answer in.
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: clear wins over enable; saturate at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - issues one buffered command to the ALU and returns its result or a timeout
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_opt,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_opt,
    output logic             alu_load,
    input  logic [WIDTH-1:0] alu_dout,
    input  logic             alu_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [2:0]       rsp_opt,
    output logic             rsp_timeout,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_opt_q, alu_opt_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [2:0]       rsp_opt_q, rsp_opt_d;
    logic             rsp_timeout_q, rsp_timeout_d;
    logic             expire;

    // Wait-cycle counter: zeroed while the load strobe is out, counts every WAIT cycle.
    alu_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q == ST_ISSUE),
        .en_i     (state_q == ST_WAIT),
        .expire_o (expire)
    );

    // Next-state and register updates; operands only change on an accepted command,
    // results only on leaving WAIT, so both stay stable while the other side looks at them.
    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_opt_d     = alu_opt_q;
        rsp_data_d    = rsp_data_q;
        rsp_opt_d     = rsp_opt_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    alu_a_d   = cmd_a;
                    alu_b_d   = cmd_b;
                    alu_opt_d = cmd_opt;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done in the expiry cycle still counts as a real result.
                if (alu_done) begin
                    rsp_data_d    = alu_dout;
                    rsp_opt_d     = alu_opt_q;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else if (expire) begin
                    rsp_data_d    = '0;
                    rsp_opt_d     = alu_opt_q;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight command or pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_opt_q     <= 3'd0;
            rsp_data_q    <= '0;
            rsp_opt_q     <= 3'd0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_opt_q     <= alu_opt_d;
            rsp_data_q    <= rsp_data_d;
            rsp_opt_q     <= rsp_opt_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // ISSUE lasts exactly one cycle and is never re-entered directly, so the strobe cannot repeat.
    assign cmd_ready   = (state_q == ST_IDLE);
    assign alu_load    = (state_q == ST_ISSUE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign busy        = (state_q != ST_IDLE);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_opt     = alu_opt_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_opt     = rsp_opt_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - vector table and scoreboard bench for alu_cmd_issuer
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    localparam int W  = 8;
    localparam int TO = 16;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] opt;
        int         delay;
        logic [7:0] data;
        logic       to;
        int         lat;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [2:0] opt;
        logic       to;
        int         lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [W-1:0] cmd_a = '0;
    logic [W-1:0] cmd_b = '0;
    logic [2:0]   cmd_opt = 3'd0;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_opt;
    logic         alu_load;
    logic [W-1:0] alu_dout = '0;
    logic         alu_done = 1'b0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_data;
    logic [2:0]   rsp_opt;
    logic         rsp_timeout;
    logic         busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   model_delay = 1;
    logic inject_done = 1'b0;
    exp_t sbq[$];
    vec_t tbl[11];

    alu_cmd_issuer #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_opt     (cmd_opt),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opt     (alu_opt),
        .alu_load    (alu_load),
        .alu_dout    (alu_dout),
        .alu_done    (alu_done),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_opt     (rsp_opt),
        .rsp_timeout (rsp_timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SHL:  return a << 1;
            OP_SHR:  return a >> 1;
            default: return {7'd0, (a < b)};
        endcase
    endfunction

    // ALU stand-in: done arrives model_delay cycles after the load cycle (0 = never).
    int         pend = 0;
    logic [7:0] res_hold = '0;
    always @(posedge clk) begin
        alu_done <= 1'b0;
        if (alu_load) begin
            res_hold <= ref_alu(alu_a, alu_b, alu_opt);
            if (model_delay == 1) begin
                alu_done <= 1'b1;
                alu_dout <= ref_alu(alu_a, alu_b, alu_opt);
            end
            pend <= (model_delay > 1) ? model_delay - 1 : 0;
        end else if (pend == 1) begin
            alu_done <= 1'b1;
            alu_dout <= res_hold;
            pend     <= 0;
        end else if (pend > 1) begin
            pend <= pend - 1;
        end
        if (inject_done) begin
            alu_done <= 1'b1;
            alu_dout <= 8'h55;
        end
    end

    // Response monitor: latency, payload, single load strobe, cmd_ready low while outstanding.
    logic outstanding = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_load = 1'b0;
    int   hs_cyc = 0;
    int   loads = 0;
    always @(negedge clk) begin
        if (rst) begin
            outstanding = 1'b0;
            prev_valid  = 1'b0;
            prev_load   = 1'b0;
        end else begin
            if (outstanding) chk("cmd_ready_low_outstanding", 32'(cmd_ready), 32'd0);
            if (alu_load) begin
                loads++;
                chk("load_not_consecutive", 32'(prev_load), 32'd0);
            end
            if (rsp_valid && !prev_valid) begin
                if (sbq.size() == 0) chk("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
                else chk("rsp_latency", 32'(cyc - hs_cyc), 32'(sbq[0].lat));
            end
            if (cmd_valid && cmd_ready) begin
                outstanding = 1'b1;
                hs_cyc      = cyc;
                loads       = 0;
            end
            if (rsp_valid && rsp_ready) begin
                if (sbq.size() == 0) begin
                    chk("rsp_without_cmd", 32'(rsp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("rsp_opt", 32'(rsp_opt), 32'(e.opt));
                    chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
                    chk("load_count", 32'(loads), 32'd1);
                end
                outstanding = 1'b0;
            end
            prev_valid = rsp_valid;
            prev_load  = alu_load;
        end
    end

    task automatic send_cmd(input vec_t v);
        exp_t e;
        bit   got;
        e = '{v.data, v.opt, v.to, v.lat};
        model_delay = v.delay;
        @(posedge clk); #1;
        cmd_a = v.a; cmd_b = v.b; cmd_opt = v.opt; cmd_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (cmd_ready) got = 1'b1;
        end
        if (got) sbq.push_back(e);
        else chk("cmd_accept_bound", 32'(got), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            chk("drain_bound", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
        @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        //            a      b      opt     dly  data   to  lat
        tbl[0]  = '{8'd12, 8'd5,  OP_ADD, 2,  8'd17, 1'b0, 4};
        tbl[1]  = '{8'd12, 8'd5,  OP_SUB, 1,  8'd7,  1'b0, 3};
        tbl[2]  = '{8'd12, 8'd5,  OP_AND, 3,  8'd4,  1'b0, 5};
        tbl[3]  = '{8'd12, 8'd5,  OP_OR,  1,  8'd13, 1'b0, 3};
        tbl[4]  = '{8'd12, 8'd5,  OP_XOR, 5,  8'd9,  1'b0, 7};
        tbl[5]  = '{8'd12, 8'd5,  OP_SHL, 2,  8'd24, 1'b0, 4};
        tbl[6]  = '{8'd12, 8'd5,  OP_SHR, 1,  8'd6,  1'b0, 3};
        tbl[7]  = '{8'd12, 8'd5,  OP_SLT, 4,  8'd0,  1'b0, 6};
        tbl[8]  = '{8'd12, 8'd5,  OP_ADD, 0,  8'd0,  1'b1, 18};
        tbl[9]  = '{8'hA0, 8'h0A, OP_OR,  16, 8'hAA, 1'b0, 18};
        tbl[10] = '{8'd12, 8'd5,  OP_SUB, 15, 8'd7,  1'b0, 17};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_alu_load", 32'(alu_load), 32'd0);
        chk("reset_alu_a", 32'(alu_a), 32'd0);
        chk("reset_alu_opt", 32'(alu_opt), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        chk("reset_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        rsp_ready = 1'b1;
        foreach (tbl[i]) begin
            send_cmd(tbl[i]);
            wait_drain();
        end

        // A done arriving with nothing outstanding must not produce a response.
        #1 inject_done = 1'b1;
        @(posedge clk); #1 inject_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("late_done_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("late_done_busy", 32'(busy), 32'd0);
        end

        // Result backpressure: response must hold for the whole stall.
        rsp_ready = 1'b0;
        send_cmd('{8'd12, 8'd5, OP_XOR, 1, 8'd9, 1'b0, 3});
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("bp_rsp_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid_hold", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data_hold", 32'(rsp_data), 32'd9);
            chk("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_cmd_ready_after", 32'(cmd_ready), 32'd1);
        chk("bp_rsp_valid_after", 32'(rsp_valid), 32'd0);
        chk("bp_queue_empty", 32'(sbq.size()), 32'd0);

        // Reset while waiting: the late done from the aborted command must be ignored.
        send_cmd('{8'd12, 8'd5, OP_AND, 6, 8'd4, 1'b0, 8});
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        sbq.delete();
        @(negedge clk);
        chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_alu_a", 32'(alu_a), 32'd0);
        chk("rst_mid_alu_opt", 32'(alu_opt), 32'd0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_rsp_data", 32'(rsp_data), 32'd0);
        repeat (8) begin
            @(negedge clk);
            chk("rst_late_done_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_late_done_busy", 32'(busy), 32'd0);
        end

        send_cmd(tbl[0]);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
